freelist: RTL and testbench

FREELIST -- requirements
Module: freelist

---
 rtl/freelist_pkg.sv | 9 +
 rtl/freelist_if.sv | 26 ++
 rtl/lane_compact.sv | 21 ++
 rtl/freelist.sv | 103 ++++++++++
 tb/tb_freelist.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freelist_pkg.sv
// Shared width constants for the rename free list.
package freelist_pkg;
  localparam int unsigned PHYS_REGS            = 64;
  localparam int unsigned PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
  localparam int unsigned DISPATCH_WIDTH       = 2;
  localparam int unsigned FL_SIZE              = PHYS_REGS - 32;
  localparam int unsigned FL_PTR_W             = $clog2(FL_SIZE);
  localparam int unsigned FL_CNT_W             = FL_PTR_W + 1;
endpackage

// File: rtl/freelist_if.sv
// Rename-side allocate and commit-side release bus of the free list.
interface freelist_if
  import freelist_pkg::*;
#(
  parameter int unsigned DW = DISPATCH_WIDTH,
  parameter int unsigned AW = PHYS_REGS_ADDR_WIDTH,
  parameter int unsigned CW = FL_CNT_W
);
  logic [DW-1:0]         alloc_req;
  logic                  alloc_ready;
  logic [DW-1:0][AW-1:0] alloc_phys;
  logic [DW-1:0]         release_en;
  logic [DW-1:0][AW-1:0] release_phys;
  logic [CW-1:0]         free_count;
  logic                  overflow_err;

  modport master (
    output alloc_req, release_en, release_phys,
    input  alloc_ready, alloc_phys, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, release_en, release_phys,
    output alloc_ready, alloc_phys, free_count, overflow_err
  );
endinterface

// File: rtl/lane_compact.sv
// Prefix popcount: per-lane count of set lanes below it, plus the total.
module lane_compact #(
  parameter int unsigned W  = 2,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         valid_i,
  output logic [W-1:0][CW-1:0] offset_o,
  output logic [CW-1:0]        count_o
);
  logic [CW-1:0] acc;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int w = 0; w < int'(W); w++) begin
      offset_o[w] = acc;
      acc         = acc + CW'(valid_i[w]);
    end
    count_o = acc;
  end
endmodule

// File: rtl/freelist.sv
// Circular free list of physical registers: compacted multi-lane allocate at head,
// compacted multi-lane release at tail, saturating count with sticky overflow flag.
module freelist #(
  parameter int unsigned PHYS_REGS      = freelist_pkg::PHYS_REGS,
  parameter int unsigned DISPATCH_WIDTH = freelist_pkg::DISPATCH_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  freelist_if.slave bus
);
  localparam int unsigned AW       = $clog2(PHYS_REGS);
  localparam int unsigned DW       = DISPATCH_WIDTH;
  localparam int unsigned FL_SIZE  = PHYS_REGS - 32;
  localparam int unsigned FL_PTR_W = $clog2(FL_SIZE);
  localparam int unsigned FL_CNT_W = FL_PTR_W + 1;
  localparam int unsigned LW       = $clog2(DW + 1);

  logic [AW-1:0]       fl_q [FL_SIZE];
  logic [AW-1:0]       fl_d [FL_SIZE];
  logic [FL_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [FL_CNT_W-1:0] cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [DW-1:0][LW-1:0] alloc_off, rel_off;
  logic [LW-1:0]         alloc_cnt, rel_cnt;
  logic [DW-1:0]         rel_vld;
  logic [FL_CNT_W-1:0]   granted, remain, room, accepted;

  // ptr < FL_SIZE and off <= DW, so one conditional subtract wraps correctly
  function automatic logic [FL_PTR_W-1:0] wrap_add(input logic [FL_PTR_W-1:0] ptr,
                                                  input logic [FL_CNT_W-1:0] off);
    logic [FL_CNT_W-1:0] s;
    s = FL_CNT_W'(ptr) + off;
    if (s >= FL_CNT_W'(FL_SIZE)) s = s - FL_CNT_W'(FL_SIZE);
    return FL_PTR_W'(s);
  endfunction

  // Physical 0 is hard-wired to x0 and never re-enters the list
  always_comb begin
    rel_vld = '0;
    for (int w = 0; w < int'(DW); w++)
      rel_vld[w] = bus.release_en[w] && (bus.release_phys[w] != '0);
  end

  lane_compact #(.W(DW), .CW(LW)) u_alloc_compact (
    .valid_i  (bus.alloc_req),
    .offset_o (alloc_off),
    .count_o  (alloc_cnt)
  );

  lane_compact #(.W(DW), .CW(LW)) u_release_compact (
    .valid_i  (rel_vld),
    .offset_o (rel_off),
    .count_o  (rel_cnt)
  );

  assign bus.alloc_ready  = (cnt_q >= FL_CNT_W'(DW));
  assign bus.free_count   = cnt_q;
  assign bus.overflow_err = ovf_q;

  always_comb begin
    bus.alloc_phys = '0;
    for (int w = 0; w < int'(DW); w++)
      bus.alloc_phys[w] = fl_q[wrap_add(head_q, FL_CNT_W'(alloc_off[w]))];
  end

  // Releases beyond the remaining room are dropped in lane order and flagged
  always_comb begin
    granted  = bus.alloc_ready ? FL_CNT_W'(alloc_cnt) : '0;
    remain   = cnt_q - granted;
    room     = FL_CNT_W'(FL_SIZE) - remain;
    ovf_d    = ovf_q;
    accepted = FL_CNT_W'(rel_cnt);
    if (FL_CNT_W'(rel_cnt) > room) begin
      accepted = room;
      ovf_d    = 1'b1;
    end
    head_d = wrap_add(head_q, granted);
    tail_d = wrap_add(tail_q, accepted);
    cnt_d  = remain + accepted;
    fl_d   = fl_q;
    for (int w = 0; w < int'(DW); w++) begin
      if (rel_vld[w] && (FL_CNT_W'(rel_off[w]) < accepted))
        fl_d[wrap_add(tail_q, FL_CNT_W'(rel_off[w]))] = bus.release_phys[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= FL_CNT_W'(FL_SIZE);
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(FL_SIZE); i++) fl_q[i] <= AW'(32 + i);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      fl_q   <= fl_d;
    end
  end
endmodule

// File: tb/tb_freelist.sv
// Directed bench for the free list: reset image, lane compaction, drain/refill,
// pointer wrap, same-cycle release/allocate, overflow and mid-burst reset.
module tb_freelist;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  freelist_if bus ();

  freelist dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req    = '0;
    bus.release_en   = '0;
    bus.release_phys = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic grant_two(input int n);
    for (int i = 0; i < n; i++) begin
      bus.alloc_req = 2'b11;
      tick();
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.free_count !== 6'd32) begin
      tests_failed++; $display("FAIL reset_free_count: got %0d expected 32", bus.free_count);
    end
    tests_run++;
    if (bus.alloc_ready !== 1'b1 || bus.overflow_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: ready=%b ovf=%b expected ready=1 ovf=0", bus.alloc_ready, bus.overflow_err);
    end
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd32 || bus.alloc_phys[1] !== 6'd33) begin
      tests_failed++;
      $display("FAIL reset_grant: got {%0d,%0d} expected {32,33}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    idle_inputs();
  endtask

  task automatic test_single_lane();
    do_reset();
    bus.alloc_req = 2'b10;
    #1;
    tests_run++;
    if (bus.alloc_phys[1] !== 6'd32) begin
      tests_failed++; $display("FAIL single_lane1: got %0d expected 32", bus.alloc_phys[1]);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd31) begin
      tests_failed++; $display("FAIL single_count: got %0d expected 31", bus.free_count);
    end
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd33 || bus.alloc_phys[1] !== 6'd34) begin
      tests_failed++;
      $display("FAIL single_next: got {%0d,%0d} expected {33,34}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    idle_inputs();
  endtask

  task automatic test_drain_refill();
    logic [5:0] e0, e1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.alloc_req = 2'b11;
      #1;
      e0 = 6'(32 + 2 * k);
      e1 = 6'(33 + 2 * k);
      tests_run++;
      if (bus.alloc_phys[0] !== e0 || bus.alloc_phys[1] !== e1) begin
        tests_failed++;
        $display("FAIL drain_grant_%0d: got {%0d,%0d} expected {%0d,%0d}",
                 k, bus.alloc_phys[0], bus.alloc_phys[1], e0, e1);
      end
      tick();
    end
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd0 || bus.alloc_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: count=%0d ready=%b expected 0/0", bus.free_count, bus.alloc_ready);
    end
    // Release into an empty list while requesting: grant must still be refused
    bus.release_en      = 2'b11;
    bus.release_phys[0] = 6'd40;
    bus.release_phys[1] = 6'd41;
    bus.alloc_req       = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_ready !== 1'b0) begin
      tests_failed++; $display("FAIL refill_same_cycle_ready: got %b expected 0", bus.alloc_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd2 || bus.alloc_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL refill_count: count=%0d ready=%b expected 2/1", bus.free_count, bus.alloc_ready);
    end
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd40 || bus.alloc_phys[1] !== 6'd41) begin
      tests_failed++;
      $display("FAIL refill_grant: got {%0d,%0d} expected {40,41}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    tick();
    idle_inputs();
    // Single release on lane 1 compacts to tail; count 1 with one request is refused
    bus.release_en      = 2'b10;
    bus.release_phys[1] = 6'd50;
    tick();
    idle_inputs();
    bus.alloc_req = 2'b01;
    #1;
    tests_run++;
    if (bus.free_count !== 6'd1 || bus.alloc_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL one_free_refused: count=%0d ready=%b expected 1/0", bus.free_count, bus.alloc_ready);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd1) begin
      tests_failed++; $display("FAIL one_free_hold: got %0d expected 1", bus.free_count);
    end
    bus.release_en      = 2'b01;
    bus.release_phys[0] = 6'd51;
    tick();
    idle_inputs();
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd50 || bus.alloc_phys[1] !== 6'd51) begin
      tests_failed++;
      $display("FAIL compact_release: got {%0d,%0d} expected {50,51}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    grant_two(15);
    bus.alloc_req = 2'b01;
    tick();
    bus.alloc_req       = 2'b00;
    bus.release_en      = 2'b11;
    bus.release_phys[0] = 6'd45;
    bus.release_phys[1] = 6'd46;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd3) begin
      tests_failed++; $display("FAIL wrap_count: got %0d expected 3", bus.free_count);
    end
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd63 || bus.alloc_phys[1] !== 6'd45) begin
      tests_failed++;
      $display("FAIL wrap_grant: got {%0d,%0d} expected {63,45}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    tick();
    bus.alloc_req       = 2'b00;
    bus.release_en      = 2'b01;
    bus.release_phys[0] = 6'd47;
    tick();
    idle_inputs();
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd46 || bus.alloc_phys[1] !== 6'd47) begin
      tests_failed++;
      $display("FAIL wrap_head_after: got {%0d,%0d} expected {46,47}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    grant_two(11);
    bus.release_en      = 2'b11;
    bus.release_phys[0] = 6'd5;
    bus.release_phys[1] = 6'd0;
    bus.alloc_req       = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd54 || bus.alloc_phys[1] !== 6'd55) begin
      tests_failed++;
      $display("FAIL same_cycle_grant: got {%0d,%0d} expected {54,55}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd9) begin
      tests_failed++; $display("FAIL same_cycle_count: got %0d expected 9", bus.free_count);
    end
    grant_two(4);
    bus.release_en      = 2'b01;
    bus.release_phys[0] = 6'd9;
    tick();
    idle_inputs();
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd5 || bus.alloc_phys[1] !== 6'd9) begin
      tests_failed++;
      $display("FAIL zero_release_dropped: got {%0d,%0d} expected {5,9}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    bus.release_en      = 2'b11;
    bus.release_phys[0] = 6'd40;
    bus.release_phys[1] = 6'd41;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.overflow_err !== 1'b1 || bus.free_count !== 6'd32) begin
      tests_failed++;
      $display("FAIL overflow_full: ovf=%b count=%0d expected 1/32", bus.overflow_err, bus.free_count);
    end
    tick();
    tests_run++;
    if (bus.overflow_err !== 1'b1) begin
      tests_failed++; $display("FAIL overflow_sticky: got %b expected 1", bus.overflow_err);
    end
    // Partial overflow: room for one, second release dropped
    do_reset();
    bus.alloc_req = 2'b01;
    tick();
    bus.alloc_req       = 2'b00;
    bus.release_en      = 2'b11;
    bus.release_phys[0] = 6'd50;
    bus.release_phys[1] = 6'd51;
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (bus.overflow_err !== 1'b1 || bus.free_count !== 6'd32) begin
      tests_failed++;
      $display("FAIL overflow_partial: ovf=%b count=%0d expected 1/32", bus.overflow_err, bus.free_count);
    end
    grant_two(15);
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd63 || bus.alloc_phys[1] !== 6'd50) begin
      tests_failed++;
      $display("FAIL overflow_kept_first: got {%0d,%0d} expected {63,50}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    tick();
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_ready !== 1'b0 || bus.free_count !== 6'd0) begin
      tests_failed++;
      $display("FAIL overflow_drained: ready=%b count=%0d expected 0/0", bus.alloc_ready, bus.free_count);
    end
    // Reset in the middle of activity wins over same-cycle requests
    bus.release_en      = 2'b11;
    bus.release_phys[0] = 6'd7;
    bus.release_phys[1] = 6'd8;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    tests_run++;
    if (bus.free_count !== 6'd32 || bus.overflow_err !== 1'b0 || bus.alloc_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midburst_reset: count=%0d ovf=%b ready=%b expected 32/0/1",
               bus.free_count, bus.overflow_err, bus.alloc_ready);
    end
    bus.alloc_req = 2'b11;
    #1;
    tests_run++;
    if (bus.alloc_phys[0] !== 6'd32 || bus.alloc_phys[1] !== 6'd33) begin
      tests_failed++;
      $display("FAIL midburst_grant: got {%0d,%0d} expected {32,33}", bus.alloc_phys[0], bus.alloc_phys[1]);
    end
    idle_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    idle_inputs();
    test_reset();
    test_single_lane();
    test_drain_refill();
    test_wrap();
    test_same_cycle();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
